xbar_rr_switch: RTL



---
 rtl/xbar_rr_switch_pkg.sv | 16 +
 rtl/xbar_rr_switch_rr_arbiter.sv | 49 ++++
 rtl/xbar_rr_switch.sv | 133 +++++++++++++
 3 files changed

// File: rtl/xbar_rr_switch_pkg.sv
// Shared defaults and helpers for the registered round-robin crossbar.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package xbar_rr_switch_pkg;

    localparam int XBAR_NI = 4;
    localparam int XBAR_NO = 4;
    localparam int XBAR_DW = 8;
    localparam int XBAR_CW = 8;

    // Largest value a w-bit unsigned counter can hold, returned 32 bits wide.
    function automatic logic [31:0] sat_max(input int w);
        return 32'((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/xbar_rr_switch_rr_arbiter.sv
// Round-robin arbiter: priority starts at ptr and descends cyclically; one-hot grant.
// Latency: grant is combinational from req; ptr updates on the edge after advance.
// Backpressure: ptr is frozen unless advance is asserted with a live request.
module rr_arbiter
    import xbar_rr_switch_pkg::*;
#(
    parameter int N  = XBAR_NI,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    logic          found;
    int            idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
                found      = 1'b1;
            end
        end
    end

    // The winner drops to lowest priority for the next round.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && (|req)) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/xbar_rr_switch.sv
// Registered NI x NO crossbar with a round-robin arbiter and one-beat register per output.
// Latency: 1 cycle from in_valid&&in_ready to out_valid.
// Backpressure: a stalled output register blocks only the inputs that target it; out-of-range beats are always accepted and counted.
module xbar_rr_switch
    import xbar_rr_switch_pkg::*;
#(
    parameter int NI   = XBAR_NI,
    parameter int NO   = XBAR_NO,
    parameter int DW   = XBAR_DW,
    parameter int DSTW = $clog2(NO),
    parameter int SRCW = $clog2(NI),
    parameter int CW   = XBAR_CW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NI-1:0]      in_valid,
    input  logic [NI*DW-1:0]   in_data,
    input  logic [NI*DSTW-1:0] in_dest,
    output logic [NI-1:0]      in_ready,
    output logic [NO-1:0]      out_valid,
    output logic [NO*DW-1:0]   out_data,
    output logic [NO*SRCW-1:0] out_src,
    input  logic [NO-1:0]      out_ready,
    output logic [CW-1:0]      drop_cnt
);

    typedef struct packed {
        logic [SRCW-1:0] src;
        logic [DW-1:0]   data;
    } beat_t;

    localparam logic [31:0] DROP_MAX = sat_max(CW);

    logic [NI-1:0]   req   [NO];
    logic [NI-1:0]   grant [NO];
    logic [SRCW-1:0] gidx  [NO];
    beat_t           obuf  [NO];
    logic [NO-1:0]   ovld;
    logic [NO-1:0]   can_load;
    logic [NO-1:0]   advance;
    logic [NI-1:0]   oor;
    logic [31:0]     drop_sum;
    logic            hit;

    always_comb begin
        for (int i = 0; i < NI; i++) begin
            oor[i] = 32'(in_dest[i*DSTW +: DSTW]) >= 32'(NO);
        end
    end

    always_comb begin
        for (int j = 0; j < NO; j++) begin
            req[j] = '0;
            for (int i = 0; i < NI; i++) begin
                req[j][i] = in_valid[i] && (32'(in_dest[i*DSTW +: DSTW]) == 32'(j));
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NO; j++) begin
            can_load[j] = !ovld[j] || out_ready[j];
            advance[j]  = can_load[j] && (|req[j]);
        end
    end

    for (genvar j = 0; j < NO; j++) begin : g_arb
        rr_arbiter #(
            .N  (NI),
            .IW (SRCW)
        ) u_arb (
            .clk       (clk),
            .rst       (rst),
            .req       (req[j]),
            .advance   (advance[j]),
            .grant     (grant[j]),
            .grant_idx (gidx[j])
        );
    end

    // Each input requests at most one output, so OR-ing grants cannot double-accept.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NI; i++) begin
            hit = 1'b0;
            for (int j = 0; j < NO; j++) begin
                hit = hit | (grant[j][i] & can_load[j]);
            end
            in_ready[i] = !rst && (oor[i] || hit);
        end
    end

    always_comb begin
        drop_sum = 32'(drop_cnt);
        for (int i = 0; i < NI; i++) begin
            if (in_valid[i] && oor[i]) begin
                drop_sum = drop_sum + 32'd1;
            end
        end
        if (drop_sum > DROP_MAX) begin
            drop_sum = DROP_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovld     <= '0;
            drop_cnt <= '0;
            for (int j = 0; j < NO; j++) begin
                obuf[j] <= '0;
            end
        end else begin
            drop_cnt <= CW'(drop_sum);
            for (int j = 0; j < NO; j++) begin
                if (can_load[j]) begin
                    ovld[j] <= advance[j];
                    if (advance[j]) begin
                        obuf[j] <= '{src: gidx[j], data: in_data[gidx[j]*DW +: DW]};
                    end
                end
            end
        end
    end

    always_comb begin
        out_valid = ovld;
        for (int j = 0; j < NO; j++) begin
            out_data[j*DW +: DW]     = obuf[j].data;
            out_src[j*SRCW +: SRCW]  = obuf[j].src;
        end
    end

endmodule
